expr_emitter: RTL and testbench

Transmit-side counterpart of the team's single-character-per-clock expression checker. Takes a packed set of decimal digits and operators, then serialises them as an ASCII expression stream of the form d(op d)*, one character per accepted handshake, e.g. "3+5*0". Intended as the stimulus source for the expression-recognition datapath and as a standalone character generator on the 8-bit ASCII bus.

---
 rtl/expr_pkg.sv | 23 ++
 rtl/expr_char_enc.sv | 23 ++
 rtl/expr_emitter.sv | 173 +++++++++++++++++
 tb/tb_expr_emitter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared definitions for the expression emitter: FSM state encoding,
// ASCII character codes and operator codes.
package expr_pkg;

    // FSM states. StTerm is only reachable when EXPR_EMITTER_TERM_EN is defined.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StDigit = 3'd1,
        StOp    = 3'd2,
        StTerm  = 3'd3,
        StDone  = 3'd4,
        StErr   = 3'd5
    } state_e;

    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_STAR = 8'h2A;
    localparam logic [7:0] CH_EQ   = 8'h3D;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/expr_char_enc.sv
// Combinational map from the current emission slot (digit, operator or
// terminator) to its 8-bit ASCII code.
module expr_char_enc
    import expr_pkg::*;
(
    input  logic       is_op_i,
    input  logic [3:0] digit_i,
    input  logic       op_bit_i,
    input  logic       is_term_i,
    output logic [7:0] ch_o
);

    // Terminator wins over operator, operator over digit.
    always_comb begin
        ch_o = CH_ZERO + {4'h0, digit_i};
        if (is_term_i) begin
            ch_o = CH_EQ;
        end else if (is_op_i) begin
            ch_o = (op_bit_i == OP_MUL) ? CH_STAR : CH_PLUS;
        end
    end

endmodule

// File: rtl/expr_emitter.sv
// Serialises a packed set of BCD digits and operators as an ASCII stream
// d(op d)*, one character per valid/ready handshake.
// Optional: define EXPR_EMITTER_TERM_EN to append '=' after the last digit.
module expr_emitter
    import expr_pkg::*;
#(
    parameter int unsigned MAX_TERMS = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [CNT_W-1:0]       n_terms,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [MAX_TERMS-2:0]   ops,
    input  logic                   ready,
    output logic [7:0]             out,
    output logic                   valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       k_q, k_d;
    logic [CNT_W-1:0]       n_q, n_d;
    logic [4*MAX_TERMS-1:0] digits_q, digits_d;
    logic [MAX_TERMS-2:0]   ops_q, ops_d;
    logic [7:0]             out_q, out_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   params_ok;
    logic                   accept;
    logic                   last_term;
    logic [3:0]             dig_sel;
    logic                   op_sel;
    logic [7:0]             enc_ch;

    assign accept    = valid_q && ready;
    assign last_term = (k_q == n_q - CNT_W'(1));

    // Legality of the start request: term count in range, used digits are BCD.
    always_comb begin
        params_ok = (n_terms != '0) && (n_terms <= CNT_W'(MAX_TERMS));
        for (int i = 0; i < MAX_TERMS; i++) begin
            if ((CNT_W'(i) < n_terms) && (digits[4*i +: 4] > 4'd9)) begin
                params_ok = 1'b0;
            end
        end
    end

    // Next-state, counter and input latching.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        digits_d = digits_q;
        ops_d    = ops_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (params_ok) begin
                        n_d      = n_terms;
                        digits_d = digits;
                        ops_d    = ops;
                        k_d      = '0;
                        state_d  = StDigit;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StDigit: begin
                if (accept) begin
                    if (last_term) begin
`ifdef EXPR_EMITTER_TERM_EN
                        state_d = StTerm;
`else
                        state_d = StDone;
`endif
                    end else begin
                        state_d = StOp;
                    end
                end
            end
            StOp: begin
                if (accept) begin
                    k_d     = k_q + CNT_W'(1);
                    state_d = StDigit;
                end
            end
            StTerm: begin
                if (accept) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Select the digit and operator addressed by the next counter value so
    // the character register is loaded in the same cycle as the state.
    always_comb begin
        dig_sel = '0;
        op_sel  = 1'b0;
        for (int i = 0; i < MAX_TERMS; i++) begin
            if (k_d == CNT_W'(i)) begin
                dig_sel = digits_d[4*i +: 4];
            end
        end
        for (int i = 0; i < MAX_TERMS - 1; i++) begin
            if (k_d == CNT_W'(i)) begin
                op_sel = ops_d[i];
            end
        end
    end

    expr_char_enc u_enc (
        .is_op_i   (state_d == StOp),
        .digit_i   (dig_sel),
        .op_bit_i  (op_sel),
        .is_term_i (state_d == StTerm),
        .ch_o      (enc_ch)
    );

    // Registered outputs derived from the next state.
    always_comb begin
        valid_d = (state_d == StDigit) || (state_d == StOp) || (state_d == StTerm);
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
        err_d   = (state_d == StErr);
        out_d   = valid_d ? enc_ch : 8'h00;
    end

    // State, latched request and output registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= StIdle;
            k_q      <= '0;
            n_q      <= '0;
            digits_q <= '0;
            ops_q    <= '0;
            out_q    <= 8'h00;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            n_q      <= n_d;
            digits_q <= digits_d;
            ops_q    <= ops_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_expr_emitter.sv
// Scoreboard bench for expr_emitter: directed starts push hand-written
// expected characters and done/err markers; a monitor pops and compares.
module tb_expr_emitter;

    localparam int MAX_TERMS = 4;
    localparam int CNT_W     = 3;
    localparam int TOK_DONE  = 256;
    localparam int TOK_ERR   = 257;
    localparam int TOK_NONE  = 999;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  n_terms = '0;
    logic [15:0] digits = '0;
    logic [2:0]  ops = '0;
    logic        ready = 1'b1;
    logic [7:0]  out;
    logic        valid, busy, done, err;

    int exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    expr_emitter #(
        .MAX_TERMS (MAX_TERMS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .n_terms (n_terms),
        .digits  (digits),
        .ops     (ops),
        .ready   (ready),
        .out     (out),
        .valid   (valid),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    function automatic int pop_exp();
        if (exp_q.size() == 0) return TOK_NONE;
        return exp_q.pop_front();
    endfunction

    task automatic push_chars(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(int'(s[i]));
    endtask

    task automatic push_expr(input string s);
        push_chars(s);
`ifdef EXPR_EMITTER_TERM_EN
        exp_q.push_back(32'h3D);
`endif
        exp_q.push_back(TOK_DONE);
    endtask

    // Issue one start cycle, then scramble the inputs to prove they were latched.
    task automatic send(input logic [2:0] n, input logic [15:0] d, input logic [2:0] o);
        @(posedge clk); #1;
        start = 1'b1; n_terms = n; digits = d; ops = o;
        @(posedge clk); #1;
        start = 1'b0; n_terms = 3'd7; digits = 16'hFFFF; ops = 3'b111;
    endtask

    task automatic wait_idle(input string name);
        int ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
        exp_q.delete();
    endtask

    // Monitor: compare every handshake, done and err pulse against the queue.
    initial begin
        logic       stall_prev = 1'b0;
        logic [7:0] prev_out   = 8'h00;
        forever begin
            @(negedge clk);
            if (clr) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && valid) chk("hold", int'(out), int'(prev_out));
                if (!valid) chk("idle_out_zero", int'(out), 0);
                if (valid && ready) chk("char", int'(out), pop_exp());
                if (done) chk("done", TOK_DONE, pop_exp());
                if (err) chk("err", TOK_ERR, pop_exp());
                stall_prev = valid && !ready;
                prev_out   = out;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        clr = 1'b0;

        // Basic stream "3+5*0"
        push_expr("3+5*0");
        send(3'd3, 16'h0053, 3'b010);
        chk("first_valid", int'(valid), 1);
        chk("first_char", int'(out), 32'h33);
        wait_idle("basic_complete");

        // Single term
        push_expr("9");
        send(3'd1, 16'h0009, 3'b000);
        wait_idle("single_complete");

        // Backpressure on '+'
        push_expr("3+5*0");
        send(3'd3, 16'h0053, 3'b010);
        @(posedge clk); #1;
        ready = 1'b0;
        chk("bp_plus_pending", int'(out), 32'h2B);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_plus_held", int'(out), 32'h2B);
        chk("bp_valid_held", int'(valid), 1);
        ready = 1'b1;
        wait_idle("bp_complete");

        // Illegal starts
        exp_q.push_back(TOK_ERR);
        send(3'd0, 16'h0012, 3'b000);
        wait_idle("err_n0");
        exp_q.push_back(TOK_ERR);
        send(3'd2, 16'h00C3, 3'b000);
        wait_idle("err_digit");
        exp_q.push_back(TOK_ERR);
        send(3'd5, 16'h1111, 3'b000);
        wait_idle("err_n_big");
        push_expr("3");
        send(3'd1, 16'h00C3, 3'b000);
        wait_idle("unused_term_ok");

        // Asynchronous clear while '*' is pending
        ready = 1'b0;
        push_chars("3+5");
        send(3'd3, 16'h0053, 3'b010);
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ready = 1'b0;
        chk("pre_clr_star", int'(out), 32'h2A);
        #2;
        clr = 1'b1;
        #1;
        chk("clr_out", int'(out), 0);
        chk("clr_valid", int'(valid), 0);
        chk("clr_busy", int'(busy), 0);
        chk("clr_queue_drained", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
        clr = 1'b0;
        ready = 1'b1;
        push_expr("7+2");
        send(3'd2, 16'h0027, 3'b000);
        wait_idle("after_clr");

        // Start while busy is ignored
        push_expr("3+5*0");
        send(3'd3, 16'h0053, 3'b010);
        start = 1'b1; n_terms = 3'd1; digits = 16'h0008;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("busy_start_ignored");
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
